// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer that feeds an external 1-bit full-adder cell LSB first
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_shift;
    logic             last_bit;

    assign in_shift = (state_q == SHIFT);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum_out  = sum_out_q;
    assign c_out    = c_out_q;
    assign fa_a     = in_shift & a_sr_q[0];
    assign fa_b     = in_shift & b_sr_q[0];
    assign fa_cin   = in_shift & carry_q;

    // State and datapath registers; reset aborts any add in flight and clears the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            sum_out_q <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            sum_out_q <= sum_out_d;
            carry_q   <= carry_d;
            c_out_q   <= c_out_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: capture on start, shift one bit per clock, publish result on the last bit
    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        sum_out_d = sum_out_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d  = fa_cout;
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = last_bit ? cnt_q : cnt_q + CW'(1);
                if (last_bit) begin
                    sum_out_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                    c_out_d   = fa_cout;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: checks the serial adder sequencer against plain a+b+cin arithmetic
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         c_in = 1'b0;
    logic         busy, done, c_out, fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic [W-1:0] sum_out;

    int checks = 0;
    int errors = 0;

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .busy(busy), .done(done), .sum_out(sum_out), .c_out(c_out),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, c_out, sum_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b c_out=%b sum_out=%h, required all zero", busy, done, c_out, sum_out);
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL reset_fa: fa=%b%b%b, required 000", fa_a, fa_b, fa_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input string name, input logic chk_last_cin, input logic exp_last_cin);
        int cyc;
        logic [W:0] exp;
        logic last_cin;
        exp = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        last_cin = 1'b0;
        checks++;
        if ({busy, fa_a, fa_b, fa_cin} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_idle: busy=%b fa=%b%b%b, required 0 000", name, busy, fa_a, fa_b, fa_cin);
        end
        a_in = a; b_in = b; c_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
        cyc = 1;
        while (!done && cyc < 50) begin
            if (cyc == W) last_cin = fa_cin;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != W + 1) begin
            errors++;
            $display("FAIL %s_latency: done in cycle %0d, required %0d", name, cyc, W + 1);
        end
        checks++;
        if ({c_out, sum_out} !== exp) begin
            errors++;
            $display("FAIL %s_result: c_out=%b sum_out=%h, required c_out=%b sum_out=%h", name, c_out, sum_out, exp[W], exp[W-1:0]);
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL %s_done_fa: fa=%b%b%b, required 000", name, fa_a, fa_b, fa_cin);
        end
        if (chk_last_cin) begin
            checks++;
            if (last_cin !== exp_last_cin) begin
                errors++;
                $display("FAIL %s_last_fa_cin: fa_cin=%b, required %b", name, last_cin, exp_last_cin);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_add(8'h5A, 8'h33, 1'b0, "add_5a_33", 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, "add_ff_01", 1'b1, 1'b1);
        run_add(8'hFF, 8'h00, 1'b1, "add_ff_00_c", 1'b0, 1'b0);
        run_add(8'h00, 8'h00, 1'b0, "add_zero", 1'b0, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, "add_max", 1'b1, 1'b1);
    endtask

    task automatic test_ignore_start();
        int pulses;
        int busy_bad;
        pulses = 0;
        busy_bad = 0;
        a_in = 8'h10; b_in = 8'h20; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= W + 3; k++) begin
            if (done) pulses++;
            if (k <= W + 1 && !busy) busy_bad++;
            start = (k == 3);
            if (k == 3) a_in = W'(1);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore_pulses: %0d done pulses, required 1", pulses);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL ignore_busy: busy low in %0d cycles, required 0", busy_bad);
        end
        checks++;
        if ({c_out, sum_out} !== 9'h030) begin
            errors++;
            $display("FAIL ignore_result: c_out=%b sum_out=%h, required c_out=0 sum_out=30", c_out, sum_out);
        end
    endtask

    task automatic test_reset_mid();
        a_in = 8'hAA; b_in = 8'h11; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, c_out, sum_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b c_out=%b sum_out=%h, required all zero", busy, done, c_out, sum_out);
        end
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (k == 1) rst_n = 1'b1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: done=%b, required 0", done);
            end
        end
        run_add(8'h77, 8'h99, 1'b1, "after_reset", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] exp;
        int adds_in;
        int dones;
        int last_done;
        adds_in = 0;
        dones = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 1000 * (W + 2) + 50; cyc++) begin
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious_done: done with no add pending at cycle %0d", cyc);
                end else begin
                    exp = q.pop_front();
                    if ({c_out, sum_out} !== exp) begin
                        errors++;
                        $display("FAIL b2b_result: c_out=%b sum_out=%h, required c_out=%b sum_out=%h", c_out, sum_out, exp[W], exp[W-1:0]);
                    end
                end
                if (last_done >= 0) begin
                    checks++;
                    if (cyc - last_done != W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: done gap %0d, required %0d", cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
                dones++;
            end
            a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
            if (!busy) begin
                if (adds_in < 1000) begin
                    q.push_back({1'b0, a_in} + {1'b0, b_in} + (W+1)'(c_in));
                    adds_in++;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            if (dones == 1000) break;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dones != 1000) begin
            errors++;
            $display("FAIL b2b_count: %0d completions, required 1000", dones);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
